fetch_unit: RTL

- Instruction-fetch front end; sits directly upstream of operational memory.
- Drives the fetch address into the memory's read-only fetch port and captures the 32-bit instruction word one cycle later.
- Buffers fetched words and hands them to decode over a valid/ready handshake.
- Handles redirects (branches, traps, user/kernel mode switches) by flushing all in-flight and buffered words.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the memory fetch port, buffers returned words, hands them to decode.
// Optional FETCH_PERF_EN adds pop/stall counters on perf_fetched/perf_stall (tied to 0 otherwise).
module fetch_unit #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] fetchAddress,
    input  logic [31:0]       fetchOutput,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Two spare bits so count + resp_v + req_v never overflows.
    localparam int CNT_W = $clog2(BUF_DEPTH + 1) + 2;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t [BUF_DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, resp_pc_q, resp_pc_d;
    logic                   req_v_q, req_v_d, resp_v_q, resp_v_d;
    logic                   pop, issue;
    logic [CNT_W-1:0]       committed;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid    = (count_q != '0);
    assign out_instr    = fifo_q[head_q].instr;
    assign out_pc       = fifo_q[head_q].pc;
    assign fetchAddress = addr_q;
    assign pop          = out_valid & out_ready;

    // Credit covers buffered words plus both memory pipeline slots, so a push never finds the buffer full.
    assign committed = count_q + CNT_W'(resp_v_q) + CNT_W'(req_v_q) - CNT_W'(pop);
    assign issue     = fetch_en & (committed < CNT_W'(BUF_DEPTH));

    always_comb begin
        fifo_d    = fifo_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        addr_d    = addr_q;
        resp_pc_d = resp_pc_q;
        req_v_d   = req_v_q;
        resp_v_d  = resp_v_q;
        if (redirect_valid) begin
            // The returning word and everything buffered belong to the old stream.
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            resp_v_d = 1'b0;
            addr_d   = redirect_pc;
            req_v_d  = fetch_en;
        end else begin
            if (resp_v_q) begin
                fifo_d[tail_q] = '{instr: fetchOutput, pc: resp_pc_q};
                tail_d         = ptr_inc(tail_q);
            end
            if (pop) head_d = ptr_inc(head_q);
            count_d   = count_q + CNT_W'(resp_v_q) - CNT_W'(pop);
            resp_v_d  = req_v_q;
            resp_pc_d = addr_q;
            req_v_d   = issue;
            addr_d    = addr_q + ADDR_W'(req_v_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            addr_q    <= RESET_PC;
            resp_pc_q <= '0;
            req_v_q   <= 1'b0;
            resp_v_q  <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            resp_pc_q <= resp_pc_d;
            req_v_q   <= req_v_d;
            resp_v_q  <= resp_v_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_stall_d   = perf_stall_q + 32'(out_valid & ~out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
`endif

endmodule
